rw_delay_shim: RTL
==================

Name: rw_delay_shim

Overview:
Parametrised, backpressure-aware delay shim between a bench-side read/write request interface and a DUT-side memory interface. Each request channel has a programmable fixed-latency pipeline followed by a credit-controlled skid FIFO. The read channel also has a delayed response return path. It is used to stress DUT and bench timing with configurable request/response latency and independent per-channel stalls.

Parameters:
ADDR_W, 3, address width (>=1)
DATA_W, 1, data width (>=1)
REQ_DLY, 2, request pipeline stages per channel (1..16)
RSP_DLY, 1, read-response delay stages (1..16)
FIFO_DEPTH, 4, per-channel credit/skid capacity (>=1; >=REQ_DLY+1 for full throughput)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
read_address  in  ADDR_W  upstream read request address
read_en  in  1  upstream read request; legal only while read_rdy=1
read_rdy  out  1  read channel has credit
read_rsp_valid  out  1  read response valid, one-cycle pulse per read
read_rsp_data  out  DATA_W  read response data
write_address  in  ADDR_W  upstream write address
write_data  in  DATA_W  upstream write data
write_en  in  1  upstream write request; legal only while write_rdy=1
write_rdy  out  1  write channel has credit
m_read_address  out  ADDR_W  downstream read address
m_read_en  out  1  downstream read strobe
m_read_rdy  in  1  downstream can accept a read
m_read_data  in  DATA_W  downstream read data, valid in the same cycle as m_read_en
m_write_address  out  ADDR_W  downstream write address
m_write_data  out  DATA_W  downstream write data
m_write_en  out  1  downstream write strobe
m_write_rdy  in  1  downstream can accept a write
proto_err  out  1  sticky: en asserted while rdy=0 on either channel

Behaviour:
- Reset (RST=1 at an edge): all stage valids, FIFOs, counters, response pipeline and proto_err are cleared. While RST=1, read_rdy, write_rdy, m_*_en, read_rsp_valid and proto_err are 0. Payload outputs are 0 when the matching valid/en is 0.
- Acceptance: a request is accepted in cycle n when en=1 and rdy=1.
- occ = valid pipeline stages + FIFO entries, per channel, from registered state.
- rdy = !RST && (occ < FIFO_DEPTH). A same-cycle pop does not add credit.
- Request pipeline: an accepted request enters stage 1 at the end of cycle n and is visible in stage k during cycle n+k.
- Downstream issue (per channel):
  - If the FIFO is non-empty, its head is presented: m_en = m_rdy, pop on m_en.
  - Otherwise, stage REQ_DLY is presented directly (bypass): m_en = stage_valid && m_rdy.
  - A stage-REQ_DLY entry that is not issued is pushed into the FIFO at that edge.
  - m_en is never 1 while m_rdy=0.
- Latency: with no backpressure and no older entries, m_en is asserted in cycle n+REQ_DLY with the payload from cycle n. Ordering is strictly FIFO within a channel. No ordering is guaranteed between the read and write channels.
- FIFO capacity: credit guarantees no overflow, so there is no drop path. Simultaneous push and pop at full occupancy is legal.
- Read response: m_read_data is captured in the cycle m_read_en=1 and shifted through RSP_DLY stages.
  - read_rsp_valid=1 with that data in cycle issue+RSP_DLY.
  - The response path has no backpressure.
- Protocol violation: en=1 while rdy=0 discards the request (it does not enter the pipeline) and sets proto_err. proto_err clears only on RST.
- Throughput: with FIFO_DEPTH >= REQ_DLY+1 and m_rdy held at 1, one request per cycle per channel is sustained.
- Reset mid-operation: all in-flight requests and responses are discarded. No m_en or read_rsp_valid is asserted in the cycle after RST deasserts.

Test Plan:
1. Hold RST=1 for 3 cycles with random inputs -> all outputs 0. In the first cycle after RST=0, read_rdy=write_rdy=1 and proto_err=0.
2. Defaults, m_write_rdy=1; write addr=5, data=1 accepted in cycle 10 -> m_write_en=1 only in cycle 12 with addr=5, data=1; write_rdy stays 1.
3. Defaults; read addr=3 accepted in cycle 20, DUT drives m_read_data=1 -> m_read_en in cycle 22, read_rsp_valid=1 with data=1 in cycle 23 only.
4. m_write_rdy=0 for 12 cycles; drive write_en whenever write_rdy=1 with addrs 0,1,2,3,... -> exactly 4 accepted, then write_rdy=0. After m_write_rdy=1: m_write_en for 4 consecutive cycles with addrs 0,1,2,3; then write_rdy=1.
5. Force write_en=1 with addr=7 while write_rdy=0 -> proto_err=1 from the next cycle and stays 1; addr 7 never appears on m_write_address. An RST pulse clears proto_err.
6. Three back-to-back reads accepted, then RST=1 for one cycle before they issue -> no m_read_en and no read_rsp_valid afterwards; read_rdy=1 after RST=0.

Source files
------------

// File: rtl/rw_delay_shim.sv
// rw_delay_shim: backpressure-aware delay shim between a bench-side
// read/write request interface and a DUT-side memory interface.
//
// Each request channel runs through a fixed REQ_DLY-stage pipeline and then
// either bypasses straight to the downstream port or parks in a skid FIFO.
// Credit (rdy) is granted only while pipeline + FIFO occupancy is below
// FIFO_DEPTH, so the FIFO can never overflow. Read data returned downstream
// is delayed by RSP_DLY stages before it is presented upstream.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   read_address/en/rdy          upstream read request, credit out
//   read_rsp_valid/data          delayed read response (no backpressure)
//   write_address/data/en/rdy    upstream write request, credit out
//   m_read_address/en/rdy/data   downstream read port
//   m_write_address/data/en/rdy  downstream write port
//   proto_err                    sticky: request seen without credit

// Generic request channel: delay pipeline, skid FIFO and credit logic.
module rw_delay_shim_chan #(
  parameter int PAY_W      = 4,
  parameter int REQ_DLY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [PAY_W-1:0] payload,
  output logic             rdy,
  output logic             viol,
  output logic             m_en,
  output logic [PAY_W-1:0] m_payload,
  input  logic             m_rdy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(REQ_DLY + FIFO_DEPTH + 1);

  // Index 0 is pipeline stage 1; index REQ_DLY-1 is the last stage.
  logic [REQ_DLY-1:0] stage_valid;
  logic [PAY_W-1:0]   stage_pay [REQ_DLY];
  logic [PAY_W-1:0]   fifo_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [OCC_W-1:0]   occ;
  logic               fifo_nonempty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Occupancy counts everything already holding credit, from registered state
  // only, so a pop in this cycle does not return credit until the next one.
  always_comb begin
    occ = OCC_W'(fifo_cnt);
    for (int k = 0; k < REQ_DLY; k++) begin
      occ = occ + OCC_W'(stage_valid[k]);
    end
  end

  assign rdy           = !RST && (occ < OCC_W'(FIFO_DEPTH));
  assign accept        = en && rdy;
  assign viol          = en && !rdy;
  assign fifo_nonempty = (fifo_cnt != '0);

  // Older entries in the FIFO always win; the last stage only bypasses to the
  // downstream port when the FIFO is empty, which keeps strict ordering.
  assign pop   = fifo_nonempty && m_rdy;
  assign issue = fifo_nonempty ? m_rdy : (stage_valid[REQ_DLY-1] && m_rdy);
  assign push  = stage_valid[REQ_DLY-1] && (fifo_nonempty || !m_rdy);

  assign m_en      = issue && !RST;
  assign m_payload = !m_en         ? '0 :
                     fifo_nonempty ? fifo_mem[rd_ptr] : stage_pay[REQ_DLY-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_valid <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      stage_valid[0] <= accept;
      for (int k = 1; k < REQ_DLY; k++) begin
        stage_valid[k] <= stage_valid[k-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset: it is only observed under a valid flag.
  always_ff @(posedge CLK) begin
    stage_pay[0] <= payload;
    for (int k = 1; k < REQ_DLY; k++) begin
      stage_pay[k] <= stage_pay[k-1];
    end
    if (push && !RST) fifo_mem[wr_ptr] <= stage_pay[REQ_DLY-1];
  end

endmodule

module rw_delay_shim #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 1,
  parameter int REQ_DLY    = 2,
  parameter int RSP_DLY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              read_en,
  output logic              read_rdy,
  output logic              read_rsp_valid,
  output logic [DATA_W-1:0] read_rsp_data,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  output logic [ADDR_W-1:0] m_read_address,
  output logic              m_read_en,
  input  logic              m_read_rdy,
  input  logic [DATA_W-1:0] m_read_data,
  output logic [ADDR_W-1:0] m_write_address,
  output logic [DATA_W-1:0] m_write_data,
  output logic              m_write_en,
  input  logic              m_write_rdy,
  output logic              proto_err
);

  localparam int WPAY_W = ADDR_W + DATA_W;

  logic              read_viol;
  logic              write_viol;
  logic              proto_err_q;
  logic [WPAY_W-1:0] m_write_pay;
  logic [RSP_DLY-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_data [RSP_DLY];

  rw_delay_shim_chan #(
    .PAY_W      (ADDR_W),
    .REQ_DLY    (REQ_DLY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_read_chan (
    .CLK       (CLK),
    .RST       (RST),
    .en        (read_en),
    .payload   (read_address),
    .rdy       (read_rdy),
    .viol      (read_viol),
    .m_en      (m_read_en),
    .m_payload (m_read_address),
    .m_rdy     (m_read_rdy)
  );

  rw_delay_shim_chan #(
    .PAY_W      (WPAY_W),
    .REQ_DLY    (REQ_DLY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_write_chan (
    .CLK       (CLK),
    .RST       (RST),
    .en        (write_en),
    .payload   ({write_address, write_data}),
    .rdy       (write_rdy),
    .viol      (write_viol),
    .m_en      (m_write_en),
    .m_payload (m_write_pay),
    .m_rdy     (m_write_rdy)
  );

  assign m_write_address = m_write_pay[WPAY_W-1:DATA_W];
  assign m_write_data    = m_write_pay[DATA_W-1:0];

  // Violating requests are simply never accepted by the channel; here we only
  // remember that one happened.
  always_ff @(posedge CLK) begin
    if (RST) begin
      proto_err_q <= 1'b0;
    end else if (read_viol || write_viol) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q && !RST;

  // Response return path: data is captured in the issue cycle, so stage k
  // holds the response issued k cycles ago.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= '0;
    end else begin
      rsp_valid[0] <= m_read_en;
      for (int k = 1; k < RSP_DLY; k++) begin
        rsp_valid[k] <= rsp_valid[k-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    rsp_data[0] <= m_read_en ? m_read_data : '0;
    for (int k = 1; k < RSP_DLY; k++) begin
      rsp_data[k] <= rsp_data[k-1];
    end
  end

  assign read_rsp_valid = rsp_valid[RSP_DLY-1] && !RST;
  assign read_rsp_data  = read_rsp_valid ? rsp_data[RSP_DLY-1] : '0;

endmodule
